// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: hunts for the sync word, reads the length byte and forwards the payload.
// Optional FCS checking (CRC-16, poly 0x1021) is built when RX_FRAME_CRC_EN is defined.
module rx_frame_ctrl #(
  parameter int                SYNC_W    = 32,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 32'h000000A7,
  parameter int                MAX_LEN   = 127,
  parameter int                TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 serial_in,
  input  logic                 serial_en,
  output logic                 s2p_start,
  input  logic [7:0]           s2p_data,
  input  logic                 s2p_data_en,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  output logic                 rx_last,
  output logic [6:0]           rx_len,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 pkt_err,
  output logic [1:0]           err_code
);

  typedef enum logic [1:0] {IDLE, HUNT, LEN, PAYLOAD} state_t;

  state_t               state, state_nxt;
  logic [SYNC_W-1:0]    sync_sr, sync_shift;
  logic [6:0]           byte_cnt, len_field;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic [TIMEOUT_W:0]   tmo_next;
  logic                 sync_hit, len_bad, tmo_hit, last_byte, crc_ok;
  logic                 start_frame, len_load, len_seen, fwd, done_evt, err_evt;
  logic [1:0]           err_kind;
  logic                 in_frame, in_frame_nxt;

  assign sync_shift   = {sync_sr[SYNC_W-2:0], serial_in};
  assign sync_hit     = serial_en && (sync_shift == SYNC_WORD);
  assign len_field    = s2p_data[6:0];
  assign last_byte    = (byte_cnt == 7'd1);
  assign tmo_next     = {1'b0, tmo_cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign tmo_hit      = (timeout != '0) && !serial_en && (tmo_next == {1'b0, timeout});
  assign in_frame     = (state == LEN) || (state == PAYLOAD);
  assign in_frame_nxt = (state_nxt == LEN) || (state_nxt == PAYLOAD);
  assign busy         = in_frame;

`ifdef RX_FRAME_CRC_EN
  logic [15:0] crc_reg;
  logic [7:0]  fcs_lo;

  // Bits enter LSB-first; the register itself shifts toward its MSB.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign len_bad = s2p_data[7] || (len_field < 7'd2) || (int'(len_field) > MAX_LEN);
  assign crc_ok  = ({s2p_data, fcs_lo} == crc_reg);

  always_ff @(posedge clk) begin
    if (!rst_n || start_frame) begin
      crc_reg <= '0;
      fcs_lo  <= '0;
    end else if (fwd) begin
      if (byte_cnt > 7'd2)       crc_reg <= crc16_byte(crc_reg, s2p_data);
      else if (byte_cnt == 7'd2) fcs_lo  <= s2p_data;
    end
  end
`else
  assign len_bad = s2p_data[7] || (len_field == 7'd0) || (int'(len_field) > MAX_LEN);
  assign crc_ok  = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    len_load    = 1'b0;
    len_seen    = 1'b0;
    fwd         = 1'b0;
    done_evt    = 1'b0;
    err_evt     = 1'b0;
    err_kind    = 2'd0;
    if (!rx_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = HUNT;
        HUNT: begin
          if (sync_hit) begin
            start_frame = 1'b1;
            state_nxt   = LEN;
          end
        end
        LEN: begin
          if (s2p_data_en) begin
            len_seen = 1'b1;
            if (len_bad) begin
              err_evt   = 1'b1;
              err_kind  = 2'd1;
              state_nxt = HUNT;
            end else begin
              len_load  = 1'b1;
              state_nxt = PAYLOAD;
            end
          end else if (tmo_hit) begin
            err_evt   = 1'b1;
            err_kind  = 2'd2;
            state_nxt = HUNT;
          end
        end
        PAYLOAD: begin
          // A byte landing on the timeout cycle wins, so a complete frame is never lost.
          if (s2p_data_en) begin
            fwd = 1'b1;
            if (last_byte) begin
              state_nxt = HUNT;
              if (crc_ok) begin
                done_evt = 1'b1;
              end else begin
                err_evt  = 1'b1;
                err_kind = 2'd3;
              end
            end
          end else if (tmo_hit) begin
            err_evt   = 1'b1;
            err_kind  = 2'd2;
            state_nxt = HUNT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sync_sr   <= '0;
      tmo_cnt   <= '0;
      byte_cnt  <= '0;
      s2p_start <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_last   <= 1'b0;
      rx_len    <= '0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= '0;
    end else begin
      state     <= state_nxt;
      s2p_start <= in_frame_nxt;
      rx_valid  <= fwd;
      rx_last   <= fwd && last_byte;
      pkt_done  <= done_evt;
      pkt_err   <= err_evt;
      if (fwd)      rx_data <= s2p_data;
      if (len_seen) rx_len  <= len_field;
      if (err_evt)          err_code <= err_kind;
      else if (start_frame) err_code <= 2'd0;
      if (len_load)  byte_cnt <= len_field;
      else if (fwd)  byte_cnt <= byte_cnt - 7'd1;
      // The sync register only listens while hunting and restarts clean after a match or an abort.
      if (state_nxt == IDLE)                                 sync_sr <= '0;
      else if ((state == HUNT) && serial_en && !sync_hit)    sync_sr <= sync_shift;
      else if ((state == HUNT) && sync_hit)                  sync_sr <= '0;
      if (in_frame && in_frame_nxt && !serial_en) tmo_cnt <= tmo_next[TIMEOUT_W-1:0];
      else                                        tmo_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl with a behavioural byte deserializer; FCS cases need RX_FRAME_CRC_EN.
module tb_rx_frame_ctrl;

  localparam int          TW   = 8;
  localparam logic [31:0] SYNC = 32'h000000A7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_en = 1'b0;
  logic [TW-1:0] timeout = '0;
  logic          serial_in = 1'b0;
  logic          serial_en = 1'b0;
  logic          s2p_start;
  logic [7:0]    s2p_data = 8'h00;
  logic          s2p_data_en = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_last, busy, pkt_done, pkt_err;
  logic [6:0]    rx_len;
  logic [1:0]    err_code;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [8:0] exp_bytes[$];
  logic [3:0] exp_evt[$];

  rx_frame_ctrl #(.SYNC_W(32), .SYNC_WORD(SYNC), .MAX_LEN(127), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .timeout(timeout),
    .serial_in(serial_in), .serial_en(serial_en), .s2p_start(s2p_start),
    .s2p_data(s2p_data), .s2p_data_en(s2p_data_en), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_last(rx_last), .rx_len(rx_len), .busy(busy),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Deserializer model: MSB-first, counts bits only while s2p_start is held.
  logic [7:0] des_sr = 8'h00;
  int         des_n  = 0;
  always @(posedge clk) begin
    s2p_data_en <= 1'b0;
    if (s2p_start !== 1'b1) begin
      des_n <= 0;
    end else if (serial_en) begin
      des_sr <= {des_sr[6:0], serial_in};
      if (des_n == 7) begin
        s2p_data    <= {des_sr[6:0], serial_in};
        s2p_data_en <= 1'b1;
        des_n       <= 0;
      end else begin
        des_n <= des_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (pkt_done || pkt_err) check_val("done_err_excl", pkt_done & pkt_err, 0);
      if (rx_valid) begin
        if (exp_bytes.size() == 0) begin
          check_val("rx_valid_unexp", rx_valid, 0);
        end else begin
          logic [8:0] e;
          e = exp_bytes.pop_front();
          check_val("rx_data", rx_data, e[7:0]);
          check_val("rx_last", rx_last, e[8]);
        end
      end else if (rx_last) begin
        check_val("rx_last_wo_valid", rx_last, 0);
      end
      if (pkt_done || pkt_err) begin
        if (exp_evt.size() == 0) begin
          check_val("evt_unexp", {pkt_err, pkt_done}, 0);
        end else begin
          logic [3:0] ev;
          ev = exp_evt.pop_front();
          check_val("evt_kind", {pkt_err, pkt_done, err_code}, ev);
        end
      end
    end
  end

  function automatic logic [15:0] ref_crc(input logic [7:0] b[$]);
    logic [15:0] crc;
    logic        fb;
    crc = 16'h0000;
    foreach (b[k]) begin
      for (int j = 0; j < 8; j++) begin
        fb  = crc[15] ^ b[k][j];
        crc = crc << 1;
        if (fb) crc = crc ^ 16'h1021;
      end
    end
    return crc;
  endfunction

  task automatic send_bit(input logic b);
    serial_in = b;
    serial_en = 1'b1;
    @(negedge clk);
    serial_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_sync();
    for (int i = 31; i > 0; i--) send_bit(SYNC[i]);
    check_val("start_before_sync", s2p_start, 0);
    send_bit(SYNC[0]);
    check_val("start_on_sync", s2p_start, 1);
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input bit corrupt, input bit settle);
    logic [7:0]  fr[$];
    logic [7:0]  len8;
    fr = pl;
`ifdef RX_FRAME_CRC_EN
    begin
      logic [15:0] fcs;
      fcs = ref_crc(pl);
      fr.push_back(fcs[7:0]);
      fr.push_back(fcs[15:8]);
    end
`endif
    if (corrupt) fr[0] = fr[0] ^ 8'h01;
    len8 = 8'(fr.size());
    foreach (fr[i]) exp_bytes.push_back({(i == fr.size() - 1), fr[i]});
    exp_evt.push_back(corrupt ? 4'b1011 : 4'b0100);
    send_sync();
    send_byte(len8);
    foreach (fr[i]) send_byte(fr[i]);
    if (settle) begin
      repeat (4) @(negedge clk);
      check_val("rx_len", rx_len, len8);
      check_val("start_after_frame", s2p_start, 0);
      check_val("busy_after_frame", busy, 0);
      check_val("bytes_pending", exp_bytes.size(), 0);
      check_val("evt_pending", exp_evt.size(), 0);
    end
  endtask

  task automatic send_bad_len(input logic [7:0] lb);
    exp_evt.push_back(4'b1001);
    send_sync();
    send_byte(lb);
    repeat (4) @(negedge clk);
    check_val("badlen_code", err_code, 1);
    check_val("badlen_rx_len", rx_len, lb[6:0]);
    check_val("badlen_start", s2p_start, 0);
    check_val("badlen_evt_pending", exp_evt.size(), 0);
  endtask

  initial begin
    logic [7:0] pl[$];
    int k;
    rx_en = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_s2p_start", s2p_start, 0);
    check_val("rst_rx_valid", rx_valid, 0);
    check_val("rst_rx_last", rx_last, 0);
    check_val("rst_rx_data", rx_data, 0);
    check_val("rst_rx_len", rx_len, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_pkt_done", pkt_done, 0);
    check_val("rst_pkt_err", pkt_err, 0);
    check_val("rst_err_code", err_code, 0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);

    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(pl, 1'b0, 1'b1);

    send_bad_len(8'h80);
    send_bad_len(8'h00);

    pl = '{8'h5A};
    send_frame(pl, 1'b0, 1'b1);

    // Bits stop after two payload bytes of a five-byte frame.
    timeout = 8'd20;
    exp_bytes.push_back({1'b0, 8'hA1});
    exp_bytes.push_back({1'b0, 8'hB2});
    exp_evt.push_back(4'b1010);
    send_sync();
    send_byte(8'h05);
    send_byte(8'hA1);
    send_byte(8'hB2);
    k = 41;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (pkt_err) begin
        k = c;
        break;
      end
    end
    check_val("tmo_cycles", k, 20);
    check_val("tmo_code", err_code, 2);
    check_val("tmo_start", s2p_start, 0);
    timeout = '0;
    repeat (2) @(negedge clk);

    // Abort mid-payload with rx_en, then recover.
    exp_bytes.push_back({1'b0, 8'hC3});
    send_sync();
    send_byte(8'h04);
    send_byte(8'hC3);
    send_byte(8'hD4);
    rx_en = 1'b0;
    repeat (3) @(negedge clk);
    check_val("abort_start", s2p_start, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_code", err_code, 0);
    check_val("abort_bytes_pending", exp_bytes.size(), 0);
    rx_en = 1'b1;
    @(negedge clk);
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(pl, 1'b0, 1'b1);

    // Back-to-back frames, the second at the largest legal length.
    pl = '{8'h01, 8'h02};
    send_frame(pl, 1'b0, 1'b0);
    pl = {};
`ifdef RX_FRAME_CRC_EN
    for (int i = 0; i < 125; i++) pl.push_back(8'(i * 3 + 7));
`else
    for (int i = 0; i < 127; i++) pl.push_back(8'(i * 3 + 7));
`endif
    send_frame(pl, 1'b0, 1'b1);

`ifdef RX_FRAME_CRC_EN
    pl = '{8'h31, 8'h32, 8'h33};
    send_frame(pl, 1'b0, 1'b1);
    check_val("crc_good_code", err_code, 0);
    send_frame(pl, 1'b1, 1'b1);
    check_val("crc_bad_code", err_code, 3);
`endif

    check_val("final_bytes_pending", exp_bytes.size(), 0);
    check_val("final_evt_pending", exp_evt.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
